led_mode_ctrl: RTL and testbench

LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

---
 rtl/led_mode_ctrl_pkg.sv | 42 ++++
 rtl/led_mode_ctrl_btn_debounce.sv | 60 ++++++
 rtl/led_mode_ctrl.sv | 117 +++++++++++
 tb/tb_led_mode_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_mode_ctrl_pkg.sv
// Shared definitions for the LED mode controller: speed period constants,
// st output encodings, FSM state type and small lookup helpers.
package led_mode_ctrl_pkg;

   localparam int CH_W = 41;

   localparam logic [CH_W-1:0] SPEED_0 = 41'd25_000_000;
   localparam logic [CH_W-1:0] SPEED_1 = 41'd10_000_000;
   localparam logic [CH_W-1:0] SPEED_2 = 41'd4_000_000;
   localparam logic [CH_W-1:0] SPEED_3 = 41'd1_000_000;

   localparam logic [1:0] ST_HOLD  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_CLEAR = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_CLEAR = 2'd3
   } state_t;

   // Period constant for a speed index.
   function automatic logic [CH_W-1:0] speed_const(input logic [1:0] idx);
      case (idx)
         2'd0:    speed_const = SPEED_0;
         2'd1:    speed_const = SPEED_1;
         2'd2:    speed_const = SPEED_2;
         default: speed_const = SPEED_3;
      endcase
   endfunction

   // st encoding for an FSM state; IDLE and PAUSE both show as hold.
   function automatic logic [1:0] st_of(input state_t s);
      case (s)
         S_RUN:   st_of = ST_RUN;
         S_CLEAR: st_of = ST_CLEAR;
         default: st_of = ST_HOLD;
      endcase
   endfunction

endpackage

// File: rtl/led_mode_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, counting debouncer and a registered
// one-cycle press pulse on each 0->1 change of the accepted level.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;
   logic             level;
   logic             level_q;

   // Two-stage synchronizer for the asynchronous button.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples;
   // a sample equal to the accepted level restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync2 != level) begin
         if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end else begin
         cnt <= '0;
      end
   end

   // Registered rising-edge detect of the accepted level.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_q <= level;
         press   <= level & ~level_q;
      end
   end

endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: button-driven IDLE/RUN/PAUSE/CLEAR controller with a
// four-step speed selector feeding the LED flasher period constant.
// Optional feature: define AUTO_CYCLE_EN to auto-advance speed while in RUN.
// Handshake: buttons are level inputs; each debouncer yields a single-cycle
// press pulse that is consumed the cycle it appears or dropped.
module led_mode_ctrl
   import led_mode_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CLEAR_CYCLES    = 2,
   parameter int AUTO_PERIOD     = 250_000_000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            btn_start,
   input  logic            btn_stop,
   input  logic            btn_speed,
   input  logic            btn_clear,
   output logic [CH_W-1:0] counter_ch,
   output logic [1:0]      st,
   output logic [1:0]      speed_idx
);

   localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

   logic start_p, stop_p, speed_p, clear_p;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
      .clk(clk), .rst(rst), .btn(btn_start), .press(start_p));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
      .clk(clk), .rst(rst), .btn(btn_stop), .press(stop_p));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
      .clk(clk), .rst(rst), .btn(btn_speed), .press(speed_p));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
      .clk(clk), .rst(rst), .btn(btn_clear), .press(clear_p));

   state_t           state, next_state;
   logic [CLR_W-1:0] clr_cnt, next_clr_cnt;

   // State, clear counter and st registers; st tracks the state it enters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         clr_cnt <= '0;
         st      <= ST_HOLD;
      end else begin
         state   <= next_state;
         clr_cnt <= next_clr_cnt;
         st      <= st_of(next_state);
      end
   end

   // Next-state logic: clear beats stop beats start; pulses not usable in
   // the current state are simply dropped.
   always_comb begin
      next_state   = state;
      next_clr_cnt = clr_cnt;
      if (clear_p) begin
         next_state   = S_CLEAR;
         next_clr_cnt = '0;
      end else begin
         case (state)
            S_IDLE:  if (start_p) next_state = S_RUN;
            S_RUN:   if (stop_p)  next_state = S_PAUSE;
            S_PAUSE: if (start_p) next_state = S_RUN;
            S_CLEAR: begin
               if (clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) begin
                  next_state   = S_IDLE;
                  next_clr_cnt = '0;
               end else begin
                  next_clr_cnt = clr_cnt + CLR_W'(1);
               end
            end
            default: next_state = S_IDLE;
         endcase
      end
   end

   logic manual_step;
   logic speed_step;

   assign manual_step = speed_p && (state != S_CLEAR);

`ifdef AUTO_CYCLE_EN
   localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

   logic [AUTO_W-1:0] auto_cnt;
   logic              auto_tick;

   assign auto_tick  = (state == S_RUN) && (auto_cnt == AUTO_W'(AUTO_PERIOD - 1));
   assign speed_step = manual_step || auto_tick;

   // RUN-only auto-advance timer; holds in IDLE/PAUSE, clears in CLEAR and
   // whenever the user steps speed manually.
   always_ff @(posedge clk) begin
      if (rst || speed_p || state == S_CLEAR) begin
         auto_cnt <= '0;
      end else if (state == S_RUN) begin
         auto_cnt <= auto_tick ? '0 : auto_cnt + AUTO_W'(1);
      end
   end
`else
   assign speed_step = manual_step;
`endif

   // Speed index and its period constant; both survive CLEAR.
   always_ff @(posedge clk) begin
      if (rst) begin
         speed_idx  <= 2'd0;
         counter_ch <= SPEED_0;
      end else begin
         if (speed_step) speed_idx <= speed_idx + 2'd1;
         counter_ch <= speed_const(speed_idx);
      end
   end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed testbench for led_mode_ctrl with short debounce and clear times.
module tb_led_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_start = 1'b0;
  logic        btn_stop  = 1'b0;
  logic        btn_speed = 1'b0;
  logic        btn_clear = 1'b0;
  logic [40:0] counter_ch;
  logic [1:0]  st;
  logic [1:0]  speed_idx;

  int n_checks = 0;
  int n_fail   = 0;

  led_mode_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CLEAR_CYCLES(2),
    .AUTO_PERIOD(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_start(btn_start),
    .btn_stop(btn_stop),
    .btn_speed(btn_speed),
    .btn_clear(btn_clear),
    .counter_ch(counter_ch),
    .st(st),
    .speed_idx(speed_idx)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // advance one cycle; inputs and samples land 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (st !== 2'd0) begin n_fail++; $display("FAIL reset_st: got %0d want 0", st); end
    n_checks++;
    if (speed_idx !== 2'd0) begin n_fail++; $display("FAIL reset_speed: got %0d want 0", speed_idx); end
    n_checks++;
    if (counter_ch !== 41'd25_000_000) begin n_fail++; $display("FAIL reset_ch: got %0d want 25000000", counter_ch); end
    // a 3-cycle glitch must not pass the 4-sample debouncer
    btn_start = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    btn_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (st !== 2'd0) begin n_fail++; $display("FAIL short_pulse_st cycle %0d: got %0d want 0", i, st); end
    end
  endtask

  task automatic test_start_held();
    btn_start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 7) begin
        n_checks++;
        if (st !== 2'd0) begin n_fail++; $display("FAIL start_early: got %0d want 0", st); end
      end
      if (i == 8) begin
        n_checks++;
        if (st !== 2'd1) begin n_fail++; $display("FAIL start_latency: got %0d want 1", st); end
      end
    end
    btn_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (st !== 2'd1) begin n_fail++; $display("FAIL start_single cycle %0d: got %0d want 1", i, st); end
    end
  endtask

  task automatic press_speed(input logic [1:0] exp_idx, input logic [40:0] exp_ch,
                             input logic [40:0] prev_ch);
    logic [1:0] prev_idx;
    prev_idx = exp_idx - 2'd1;
    btn_speed = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if (speed_idx !== prev_idx) begin n_fail++; $display("FAIL speed_early: got %0d want %0d", speed_idx, prev_idx); end
    tick();
    n_checks++;
    if (speed_idx !== exp_idx) begin n_fail++; $display("FAIL speed_idx: got %0d want %0d", speed_idx, exp_idx); end
    n_checks++;
    if (counter_ch !== prev_ch) begin n_fail++; $display("FAIL ch_lag: got %0d want %0d", counter_ch, prev_ch); end
    tick();
    n_checks++;
    if (counter_ch !== exp_ch) begin n_fail++; $display("FAIL ch_step: got %0d want %0d", counter_ch, exp_ch); end
    btn_speed = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_speed();
    press_speed(2'd1, 41'd10_000_000, 41'd25_000_000);
    press_speed(2'd2, 41'd4_000_000,  41'd10_000_000);
    press_speed(2'd3, 41'd1_000_000,  41'd4_000_000);
    press_speed(2'd0, 41'd25_000_000, 41'd1_000_000);
    press_speed(2'd1, 41'd10_000_000, 41'd25_000_000);
  endtask

  task automatic test_stop_clear();
    btn_stop  = 1'b1;
    btn_clear = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if (st !== 2'd1) begin n_fail++; $display("FAIL sc_early: got %0d want 1", st); end
    tick();
    n_checks++;
    if (st !== 2'd2) begin n_fail++; $display("FAIL sc_clear1: got %0d want 2", st); end
    tick();
    n_checks++;
    if (st !== 2'd2) begin n_fail++; $display("FAIL sc_clear2: got %0d want 2", st); end
    tick();
    n_checks++;
    if (st !== 2'd0) begin n_fail++; $display("FAIL sc_idle: got %0d want 0", st); end
    n_checks++;
    if (speed_idx !== 2'd1) begin n_fail++; $display("FAIL sc_speed: got %0d want 1", speed_idx); end
    n_checks++;
    if (counter_ch !== 41'd10_000_000) begin n_fail++; $display("FAIL sc_ch: got %0d want 10000000", counter_ch); end
    btn_stop  = 1'b0;
    btn_clear = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (st !== 2'd0) begin n_fail++; $display("FAIL sc_after cycle %0d: got %0d want 0", i, st); end
    end
  endtask

  task automatic test_clear_ignores_speed();
    btn_clear = 1'b1;
    tick();
    btn_speed = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if (st !== 2'd2) begin n_fail++; $display("FAIL cis_clear: got %0d want 2", st); end
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (st !== 2'd0) begin n_fail++; $display("FAIL cis_idle: got %0d want 0", st); end
    n_checks++;
    if (speed_idx !== 2'd1) begin n_fail++; $display("FAIL cis_speed: got %0d want 1", speed_idx); end
    btn_clear = 1'b0;
    btn_speed = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (speed_idx !== 2'd1) begin n_fail++; $display("FAIL cis_speed_late: got %0d want 1", speed_idx); end
  endtask

  task automatic test_reset_in_clear();
    btn_clear = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if (st !== 2'd2) begin n_fail++; $display("FAIL ric_clear: got %0d want 2", st); end
    rst = 1'b1;
    btn_clear = 1'b0;
    tick();
    n_checks++;
    if (st !== 2'd0) begin n_fail++; $display("FAIL ric_st: got %0d want 0", st); end
    n_checks++;
    if (speed_idx !== 2'd0) begin n_fail++; $display("FAIL ric_speed: got %0d want 0", speed_idx); end
    n_checks++;
    if (counter_ch !== 41'd25_000_000) begin n_fail++; $display("FAIL ric_ch: got %0d want 25000000", counter_ch); end
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if (st !== 2'd0) begin n_fail++; $display("FAIL ric_after cycle %0d: got %0d want 0", i, st); end
    end
  endtask

  task automatic test_held_through_reset();
    btn_start = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) begin
        n_checks++;
        if (st !== 2'd0) begin n_fail++; $display("FAIL htr_early: got %0d want 0", st); end
      end
      if (i == 8) begin
        n_checks++;
        if (st !== 2'd1) begin n_fail++; $display("FAIL htr_run: got %0d want 1", st); end
      end
    end
    btn_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

`ifdef AUTO_CYCLE_EN
  task automatic test_auto();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    btn_start = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if (st !== 2'd1) begin n_fail++; $display("FAIL auto_run: got %0d want 1", st); end
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (i == 2) btn_start = 1'b0;
      if (i == 19 || i == 20 || i == 39 || i == 40 || i == 45) begin
        logic [1:0] exp;
        exp = (i >= 40) ? 2'd2 : (i >= 20) ? 2'd1 : 2'd0;
        n_checks++;
        if (speed_idx !== exp) begin n_fail++; $display("FAIL auto_speed at %0d: got %0d want %0d", i, speed_idx, exp); end
      end
    end
    btn_stop = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    btn_stop = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    n_checks++;
    if (st !== 2'd0) begin n_fail++; $display("FAIL auto_pause: got %0d want 0", st); end
    n_checks++;
    if (speed_idx !== 2'd2) begin n_fail++; $display("FAIL auto_hold: got %0d want 2", speed_idx); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef AUTO_CYCLE_EN
    test_auto();
`else
    test_start_held();
    test_speed();
    test_stop_clear();
    test_clear_ignores_speed();
    test_reset_in_clear();
    test_held_through_reset();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
